cv_ctrl_ports: RTL and testbench

Parametrised ColecoVision/SG-1000 controller-port engine. It replaces the two-port combinational keypad mapper in the console top. It maps NPORTS MiSTer joystick words onto the console's port lines: p1–p4 data, p6 fire, p7/p9 spinner. It sits between `hps_io` and `cv_console`, and adds registered outputs, rotating player-to-port assignment, and a Super Action spinner quadrature generator per port.

---
 rtl/cv_ctrl_pkg.sv | 141 ++++++++++++++
 rtl/cv_spinner_quad.sv | 73 +++++++
 rtl/cv_ctrl_ports.sv | 138 +++++++++++++
 tb/tb_cv_ctrl_ports.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// cv_ctrl_pkg: shared constants and helpers for the ColecoVision controller-port engine.
// Keypad codes, joystick bit positions, quadrature phase enum, saturating add,
// and the per-path port-line encoders. The spinner logic that uses the phase
// helpers is only built when CV_SPINNER_EN is defined.
package cv_ctrl_pkg;

  // Width of one joystick word and of the part of it the ports use
  localparam int unsigned JOY_WORD_W = 32;
  localparam int unsigned JOY_USED_W = 20;

  // Joystick word bit positions (active high)
  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_FIRE1  = 4;
  localparam int unsigned JOY_FIRE2  = 5;
  localparam int unsigned JOY_STAR   = 6;
  localparam int unsigned JOY_HASH   = 7;
  localparam int unsigned JOY_DIGIT0 = 8;
  localparam int unsigned JOY_PURPLE = 18;
  localparam int unsigned JOY_BLUE   = 19;

  // Keypad codes as seen on {p1,p2,p3,p4}, active low
  localparam logic [3:0] KP_0      = 4'b0011;
  localparam logic [3:0] KP_1      = 4'b1110;
  localparam logic [3:0] KP_2      = 4'b1101;
  localparam logic [3:0] KP_3      = 4'b0110;
  localparam logic [3:0] KP_4      = 4'b0001;
  localparam logic [3:0] KP_5      = 4'b1001;
  localparam logic [3:0] KP_6      = 4'b0111;
  localparam logic [3:0] KP_7      = 4'b1100;
  localparam logic [3:0] KP_8      = 4'b1000;
  localparam logic [3:0] KP_9      = 4'b1011;
  localparam logic [3:0] KP_STAR   = 4'b1010;
  localparam logic [3:0] KP_HASH   = 4'b0101;
  localparam logic [3:0] KP_PURPLE = 4'b0100;
  localparam logic [3:0] KP_BLUE   = 4'b0010;
  localparam logic [3:0] KP_NONE   = 4'b1111;

  // Quadrature phases; forward order is Q0 -> Q1 -> Q2 -> Q3 -> Q0
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_phase_e;

  // Arithmetic width for the saturating add; wide enough for SPIN_W up to 30
  localparam int unsigned SAT_W = 34;

  // Signed add clamped to [lo, hi]
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    logic signed [SAT_W-1:0] s;
    s = a + b;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

  // Next phase one step forward, or one step back when rev is set
  function automatic quad_phase_e quad_next(input quad_phase_e ph, input logic rev);
    quad_phase_e n;
    case (ph)
      Q0:      n = rev ? Q3 : Q1;
      Q1:      n = rev ? Q0 : Q2;
      Q2:      n = rev ? Q1 : Q3;
      Q3:      n = rev ? Q2 : Q0;
      default: n = Q0;
    endcase
    return n;
  endfunction

  // Line levels {A,B} for a phase
  function automatic logic [1:0] quad_ab(input quad_phase_e ph);
    logic [1:0] ab;
    case (ph)
      Q0:      ab = 2'b11;
      Q1:      ab = 2'b01;
      Q2:      ab = 2'b00;
      Q3:      ab = 2'b10;
      default: ab = 2'b11;
    endcase
    return ab;
  endfunction

  // Keypad data term: highest-priority pressed key, all 1s when deselected
  function automatic logic [3:0] kp_data(input logic sel_n, input logic [JOY_USED_W-1:0] w);
    logic [3:0] code;
    if (sel_n)                   code = KP_NONE;
    else if (w[JOY_DIGIT0 + 0])  code = KP_0;
    else if (w[JOY_DIGIT0 + 1])  code = KP_1;
    else if (w[JOY_DIGIT0 + 2])  code = KP_2;
    else if (w[JOY_DIGIT0 + 3])  code = KP_3;
    else if (w[JOY_DIGIT0 + 4])  code = KP_4;
    else if (w[JOY_DIGIT0 + 5])  code = KP_5;
    else if (w[JOY_DIGIT0 + 6])  code = KP_6;
    else if (w[JOY_DIGIT0 + 7])  code = KP_7;
    else if (w[JOY_DIGIT0 + 8])  code = KP_8;
    else if (w[JOY_DIGIT0 + 9])  code = KP_9;
    else if (w[JOY_STAR])        code = KP_STAR;
    else if (w[JOY_HASH])        code = KP_HASH;
    else if (w[JOY_PURPLE])      code = KP_PURPLE;
    else if (w[JOY_BLUE])        code = KP_BLUE;
    else                         code = KP_NONE;
    return code;
  endfunction

  // Joystick data term ~{up,down,left,right}, all 1s when deselected
  function automatic logic [3:0] js_data(input logic sel_n, input logic [JOY_USED_W-1:0] w);
    logic [3:0] d;
    if (sel_n) d = 4'b1111;
    else       d = ~{w[JOY_UP], w[JOY_DOWN], w[JOY_LEFT], w[JOY_RIGHT]};
    return d;
  endfunction

  // Fire terms: fire2 on the keypad side, fire1 on the joystick side
  function automatic logic kp_fire(input logic sel_n, input logic [JOY_USED_W-1:0] w);
    logic f;
    if (sel_n) f = 1'b1;
    else       f = ~w[JOY_FIRE2];
    return f;
  endfunction

  function automatic logic js_fire(input logic sel_n, input logic [JOY_USED_W-1:0] w);
    logic f;
    if (sel_n) f = 1'b1;
    else       f = ~w[JOY_FIRE1];
    return f;
  endfunction

endpackage

// File: rtl/cv_spinner_quad.sv
// cv_spinner_quad: one Super Action spinner channel. A saturating signed
// accumulator collects strobed deltas; on each shared step tick a non-zero
// accumulator moves the quadrature phase one step in its sign direction and
// drains by one. Only built when CV_SPINNER_EN is defined.
module cv_spinner_quad
  import cv_ctrl_pkg::*;
#(
  parameter int SPIN_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clk_en_i,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic              stb_i,
  input  logic [SPIN_W-1:0] delta_i,
  output logic              a_o,
  output logic              b_o
);

  localparam int ACC_W = SPIN_W + 2;
  localparam logic signed [SAT_W-1:0] ACC_MAX = (34'sd1 <<< (SPIN_W + 1)) - 34'sd1;
  localparam logic signed [SAT_W-1:0] ACC_MIN = ~ACC_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SAT_W-1:0] acc_ext_s, base_s, add_s;
  logic                    step_go_s;
  logic                    rev_s;
  quad_phase_e             phase_q;
  logic                    a_q, b_q;

  // Next accumulator: drain one toward zero on a step, add the strobed delta, clamp
  always_comb begin
    acc_ext_s = {{(SAT_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    rev_s     = acc_q[ACC_W-1];
    step_go_s = step_i & (acc_q != {ACC_W{1'b0}}) & ~clear_i;
    if (step_go_s) begin
      if (rev_s) base_s = acc_ext_s + 34'sd1;
      else       base_s = acc_ext_s - 34'sd1;
    end else begin
      base_s = acc_ext_s;
    end
    if (stb_i) add_s = {{(SAT_W - SPIN_W){delta_i[SPIN_W-1]}}, delta_i};
    else       add_s = {SAT_W{1'b0}};
    if (clear_i) acc_d = {ACC_W{1'b0}};
    else         acc_d = ACC_W'(sat_add(base_s, add_s, ACC_MIN, ACC_MAX));
  end

  // Accumulator register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q <= {ACC_W{1'b0}};
    end else if (clk_en_i) begin
      acc_q <= acc_d;
    end
  end

  // Phase FSM with registered A/B lines; a zero accumulator holds the phase
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_q <= Q0;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
    end else if (clk_en_i && step_go_s) begin
      phase_q    <= quad_next(phase_q, rev_s);
      {a_q, b_q} <= quad_ab(quad_next(phase_q, rev_s));
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/cv_ctrl_ports.sv
// cv_ctrl_ports: ColecoVision/SG-1000 controller-port engine. Maps NPORTS
// joystick words onto registered port lines with a rotating player-to-port
// assignment. Define CV_SPINNER_EN to build the per-port spinner quadrature
// generators; without it spin_a_o/spin_b_o are held high.
module cv_ctrl_ports
  import cv_ctrl_pkg::*;
#(
  parameter  int NPORTS   = 2,
  parameter  int SPIN_W   = 8,
  parameter  int SPIN_DIV = 256,
  localparam int ROT_W    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clk_en_i,
  input  logic [ROT_W-1:0]         rotate_i,
  input  logic [NPORTS*32-1:0]     joy_i,
  input  logic [NPORTS*SPIN_W-1:0] spin_i,
  input  logic [NPORTS-1:0]        spin_stb_i,
  input  logic [NPORTS-1:0]        sel_kp_n_i,
  input  logic [NPORTS-1:0]        sel_js_n_i,
  output logic [NPORTS*4-1:0]      ctrl_n_o,
  output logic [NPORTS-1:0]        fire_n_o,
  output logic [NPORTS-1:0]        spin_a_o,
  output logic [NPORTS-1:0]        spin_b_o
);

  // Joystick index feeding physical port p under the current rotation
  function automatic int src_of(input int p, input logic [ROT_W-1:0] rot);
    return (p + int'(rot)) % NPORTS;
  endfunction

  logic [JOY_USED_W-1:0] jsel_s [NPORTS];
  logic [NPORTS*4-1:0]   ctrl_d, ctrl_q;
  logic [NPORTS-1:0]     fire_d, fire_q;
  logic                  unused_joy_s;

  // Upper joystick word bits carry nothing for the console ports
  assign unused_joy_s = ^joy_i;

  // Route each joystick word to its physical port
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      jsel_s[p] = joy_i[src_of(p, rotate_i)*JOY_WORD_W +: JOY_USED_W];
    end
  end

  // Combine keypad and joystick paths; an inactive path drives all 1s
  always_comb begin
    ctrl_d = {(NPORTS*4){1'b1}};
    fire_d = {NPORTS{1'b1}};
    for (int p = 0; p < NPORTS; p++) begin
      ctrl_d[p*4 +: 4] = kp_data(sel_kp_n_i[p], jsel_s[p]) & js_data(sel_js_n_i[p], jsel_s[p]);
      fire_d[p]        = kp_fire(sel_kp_n_i[p], jsel_s[p]) & js_fire(sel_js_n_i[p], jsel_s[p]);
    end
  end

  // Port data and fire lines, updated once per enable
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_q <= {(NPORTS*4){1'b1}};
      fire_q <= {NPORTS{1'b1}};
    end else if (clk_en_i) begin
      ctrl_q <= ctrl_d;
      fire_q <= fire_d;
    end
  end

  assign ctrl_n_o = ctrl_q;
  assign fire_n_o = fire_q;

`ifdef CV_SPINNER_EN
  localparam int TMR_W = $clog2(SPIN_DIV);

  logic [TMR_W-1:0]  tmr_q;
  logic              tick_s;
  logic [ROT_W-1:0]  rot_q;
  logic              rot_chg_s;
  logic [NPORTS-1:0] stb_sel_s;
  logic [SPIN_W-1:0] dsel_s [NPORTS];

  assign tick_s    = (tmr_q == TMR_W'(SPIN_DIV - 1));
  assign rot_chg_s = (rotate_i != rot_q);

  // Shared free-running step timer, modulo SPIN_DIV
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmr_q <= {TMR_W{1'b0}};
    end else if (clk_en_i) begin
      if (tick_s) tmr_q <= {TMR_W{1'b0}};
      else        tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // Last rotation seen on an enable; a difference clears every accumulator
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rot_q <= {ROT_W{1'b0}};
    end else if (clk_en_i) begin
      rot_q <= rotate_i;
    end
  end

  // Route spinner strobe and delta through the same rotation as the joystick
  always_comb begin
    stb_sel_s = {NPORTS{1'b0}};
    for (int p = 0; p < NPORTS; p++) begin
      stb_sel_s[p] = spin_stb_i[src_of(p, rotate_i)];
      dsel_s[p]    = spin_i[src_of(p, rotate_i)*SPIN_W +: SPIN_W];
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_spin
    cv_spinner_quad #(
      .SPIN_W (SPIN_W)
    ) u_quad (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clk_en_i  (clk_en_i),
      .step_i    (tick_s),
      .clear_i   (rot_chg_s),
      .stb_i     (stb_sel_s[p]),
      .delta_i   (dsel_s[p]),
      .a_o       (spin_a_o[p]),
      .b_o       (spin_b_o[p])
    );
  end
`else
  localparam int unused_div_p = SPIN_DIV;
  logic unused_spin_s;

  // Without the spinner the quadrature lines idle high and spinner inputs are ignored
  assign unused_spin_s = ^{spin_i, spin_stb_i} ^ (unused_div_p > 0);
  assign spin_a_o      = {NPORTS{1'b1}};
  assign spin_b_o      = {NPORTS{1'b1}};
`endif

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Self-checking bench for cv_ctrl_ports: directed scenarios plus randomized
// stimulus against a behavioural model of the port mapping and spinner.
module tb_cv_ctrl_ports;

  localparam int NPORTS   = 2;
  localparam int SPIN_W   = 8;
  localparam int SPIN_DIV = 4;
  localparam int ROT_W    = 1;
  localparam int ACC_MAX  = (1 << (SPIN_W + 1)) - 1;
  localparam int ACC_MIN  = -(1 << (SPIN_W + 1));
`ifdef CV_SPINNER_EN
  localparam bit SPIN_ON = 1'b1;
`else
  localparam bit SPIN_ON = 1'b0;
`endif

  // Keypad priority order and codes, highest priority first
  localparam int         KP_BIT [14] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 6, 7, 18, 19};
  localparam logic [3:0] KP_VAL [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001, 4'b0111,
                                         4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010};
  // {A,B} for phases Q0..Q3
  localparam logic [1:0] AB_OF [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     clk_en;
  logic [ROT_W-1:0]         rotate;
  logic [NPORTS*32-1:0]     joy;
  logic [NPORTS*SPIN_W-1:0] spin;
  logic [NPORTS-1:0]        stb;
  logic [NPORTS-1:0]        sel_kp_n;
  logic [NPORTS-1:0]        sel_js_n;
  logic [NPORTS*4-1:0]      ctrl_n;
  logic [NPORTS-1:0]        fire_n;
  logic [NPORTS-1:0]        spa;
  logic [NPORTS-1:0]        spb;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0] m_ctrl [NPORTS];
  logic       m_fire [NPORTS];
  int         m_acc  [NPORTS];
  int         m_ph   [NPORTS];
  int         m_en_cnt;
  int         m_rot_prev;

  cv_ctrl_ports #(
    .NPORTS   (NPORTS),
    .SPIN_W   (SPIN_W),
    .SPIN_DIV (SPIN_DIV)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .clk_en_i   (clk_en),
    .rotate_i   (rotate),
    .joy_i      (joy),
    .spin_i     (spin),
    .spin_stb_i (stb),
    .sel_kp_n_i (sel_kp_n),
    .sel_js_n_i (sel_js_n),
    .ctrl_n_o   (ctrl_n),
    .fire_n_o   (fire_n),
    .spin_a_o   (spa),
    .spin_b_o   (spb)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] kp_ref(input logic [31:0] w);
    logic [3:0] r;
    r = 4'b1111;
    for (int k = 13; k >= 0; k--) if (w[KP_BIT[k]]) r = KP_VAL[k];
    return r;
  endfunction

  function automatic logic [1:0] exp_ab(input int p);
    return SPIN_ON ? AB_OF[m_ph[p]] : 2'b11;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NPORTS; p++) begin
      m_ctrl[p] = 4'b1111; m_fire[p] = 1'b1; m_acc[p] = 0; m_ph[p] = 0;
    end
    m_en_cnt = 0; m_rot_prev = 0;
  endtask

  task automatic clear_inputs();
    rotate = '0; joy = '0; spin = '0; stb = '0;
    sel_kp_n = '1; sel_js_n = '1;
  endtask

  task automatic do_reset();
    clk_en = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    #1;
  endtask

  // One clock-enable pulse; the model advances with the same inputs
  task automatic step_en();
    int src; int dv; int d; int dir; bit rot_changed; logic [31:0] w;
    @(negedge clk);
    clk_en = 1'b1;
    rot_changed = (int'(rotate) != m_rot_prev);
    for (int p = 0; p < NPORTS; p++) begin
      src = (p + int'(rotate)) % NPORTS;
      w = joy[src*32 +: 32];
      m_ctrl[p] = (sel_kp_n[p] ? 4'b1111 : kp_ref(w)) & (sel_js_n[p] ? 4'b1111 : ~{w[3], w[2], w[1], w[0]});
      m_fire[p] = (sel_kp_n[p] | ~w[5]) & (sel_js_n[p] | ~w[4]);
      if (rot_changed) begin
        m_acc[p] = 0;
      end else begin
        d = 0;
        if ((m_en_cnt % SPIN_DIV) == SPIN_DIV - 1 && m_acc[p] != 0) begin
          dir = (m_acc[p] > 0) ? 1 : -1;
          m_ph[p] = (m_ph[p] + dir + 4) % 4;
          d = -dir;
        end
        if (stb[src]) begin
          dv = $signed(spin[src*SPIN_W +: SPIN_W]);
          d += dv;
        end
        m_acc[p] = m_acc[p] + d;
        if (m_acc[p] > ACC_MAX) m_acc[p] = ACC_MAX;
        if (m_acc[p] < ACC_MIN) m_acc[p] = ACC_MIN;
      end
    end
    m_rot_prev = int'(rotate);
    m_en_cnt++;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctrl_n !== 8'hFF) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_n, 8'hFF); end
    checks++; if (fire_n !== 2'b11) begin errors++; $display("FAIL reset_fire: got %b expected %b", fire_n, 2'b11); end
    checks++; if ({spa, spb} !== 4'b1111) begin errors++; $display("FAIL reset_spin: got %b expected %b", {spa, spb}, 4'b1111); end
    repeat (3) step_en();
    checks++; if (ctrl_n !== 8'hFF) begin errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl_n, 8'hFF); end
    checks++; if (fire_n !== 2'b11) begin errors++; $display("FAIL idle_fire: got %b expected %b", fire_n, 2'b11); end
  endtask

  task automatic test_keypad();
    clear_inputs();
    sel_kp_n = 2'b10;
    joy[8] = 1'b1; joy[12] = 1'b1;
    step_en();
    checks++; if (ctrl_n[3:0] !== 4'b0011) begin errors++; $display("FAIL kp_digit0_wins: got %b expected %b", ctrl_n[3:0], 4'b0011); end
    checks++; if (ctrl_n[7:4] !== 4'b1111) begin errors++; $display("FAIL kp_other_port: got %b expected %b", ctrl_n[7:4], 4'b1111); end
    joy[5] = 1'b1;
    step_en();
    checks++; if (fire_n !== 2'b10) begin errors++; $display("FAIL kp_fire2: got %b expected %b", fire_n, 2'b10); end
    // Each key alone on port 1
    clear_inputs();
    sel_kp_n = 2'b01;
    for (int k = 0; k < 14; k++) begin
      joy = '0;
      joy[32 + KP_BIT[k]] = 1'b1;
      step_en();
      checks++; if (ctrl_n[7:4] !== KP_VAL[k]) begin errors++; $display("FAIL kp_key%0d: got %b expected %b", k, ctrl_n[7:4], KP_VAL[k]); end
    end
  endtask

  task automatic test_combined();
    clear_inputs();
    sel_kp_n = 2'b00; sel_js_n = 2'b00;
    joy[3] = 1'b1; joy[0] = 1'b1; joy[4] = 1'b1; joy[9] = 1'b1;
    step_en();
    checks++; if (ctrl_n[3:0] !== 4'b0110) begin errors++; $display("FAIL both_paths_ctrl: got %b expected %b", ctrl_n[3:0], 4'b0110); end
    checks++; if (fire_n !== 2'b10) begin errors++; $display("FAIL both_paths_fire: got %b expected %b", fire_n, 2'b10); end
    checks++; if (ctrl_n[7:4] !== 4'b1111) begin errors++; $display("FAIL both_paths_idle: got %b expected %b", ctrl_n[7:4], 4'b1111); end
  endtask

  task automatic test_rotate();
    clear_inputs();
    sel_js_n = 2'b00;
    rotate = 1'b1;
    joy[3] = 1'b1;
    step_en();
    checks++; if (ctrl_n[7:4] !== 4'b0111) begin errors++; $display("FAIL rot_port1: got %b expected %b", ctrl_n[7:4], 4'b0111); end
    checks++; if (ctrl_n[3:0] !== 4'b1111) begin errors++; $display("FAIL rot_port0: got %b expected %b", ctrl_n[3:0], 4'b1111); end
  endtask

  task automatic test_spinner();
    logic [1:0] prev; int changes;
    clear_inputs();
    do_reset();
    stb[0] = 1'b1; spin[7:0] = 8'd3;
    step_en();
    stb = '0;
    prev = 2'b11; changes = 0;
    for (int i = 0; i < 20; i++) begin
      step_en();
      if ({spa[0], spb[0]} != prev) changes++;
      prev = {spa[0], spb[0]};
      checks++; if ({spa[0], spb[0]} !== exp_ab(0)) begin errors++; $display("FAIL spin_fwd_ab: got %b expected %b", {spa[0], spb[0]}, exp_ab(0)); end
    end
    checks++; if (changes !== (SPIN_ON ? 3 : 0)) begin errors++; $display("FAIL spin_fwd_steps: got %0d expected %0d", changes, SPIN_ON ? 3 : 0); end
    checks++; if (prev !== (SPIN_ON ? 2'b10 : 2'b11)) begin errors++; $display("FAIL spin_hold_q3: got %b expected %b", prev, SPIN_ON ? 2'b10 : 2'b11); end
    stb[0] = 1'b1; spin[7:0] = 8'hFE;
    step_en();
    stb = '0;
    if ({spa[0], spb[0]} != prev) changes = 1; else changes = 0;
    prev = {spa[0], spb[0]};
    for (int i = 0; i < 20; i++) begin
      step_en();
      if ({spa[0], spb[0]} != prev) changes++;
      prev = {spa[0], spb[0]};
    end
    checks++; if (changes !== (SPIN_ON ? 2 : 0)) begin errors++; $display("FAIL spin_rev_steps: got %0d expected %0d", changes, SPIN_ON ? 2 : 0); end
    checks++; if (prev !== (SPIN_ON ? 2'b01 : 2'b11)) begin errors++; $display("FAIL spin_rev_q1: got %b expected %b", prev, SPIN_ON ? 2'b01 : 2'b11); end
    checks++; if ({spa[1], spb[1]} !== 2'b11) begin errors++; $display("FAIL spin_port1_idle: got %b expected %b", {spa[1], spb[1]}, 2'b11); end
  endtask

  task automatic test_saturation();
    logic [1:0] prev; int changes;
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      stb[0] = 1'b1; spin[7:0] = 8'd127;
      step_en();
    end
    stb = '0;
    prev = {spa[0], spb[0]}; changes = 0;
    for (int i = 0; i < 2100 && m_acc[0] != 0; i++) begin
      step_en();
      if ({spa[0], spb[0]} != prev) changes++;
      prev = {spa[0], spb[0]};
      checks++; if ({spa[0], spb[0]} !== exp_ab(0)) begin errors++; $display("FAIL sat_drain_ab: got %b expected %b", {spa[0], spb[0]}, exp_ab(0)); end
    end
    checks++; if (changes !== (SPIN_ON ? ACC_MAX : 0)) begin errors++; $display("FAIL sat_step_count: got %0d expected %0d", changes, SPIN_ON ? ACC_MAX : 0); end
    // Refill, then a rotation change empties every accumulator
    stb[0] = 1'b1; spin[7:0] = 8'd100;
    step_en();
    stb = '0;
    repeat (3) step_en();
    prev = {spa[0], spb[0]}; changes = 0;
    rotate = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_en();
      if ({spa[0], spb[0]} != prev) changes++;
      prev = {spa[0], spb[0]};
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL rot_clear_steps: got %0d expected %0d", changes, 0); end
    checks++; if ({spa[1], spb[1]} !== 2'b11) begin errors++; $display("FAIL rot_clear_port1: got %b expected %b", {spa[1], spb[1]}, 2'b11); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < NPORTS; p++) begin
        joy[p*32 +: 32] = $urandom() & $urandom() & 32'h000F_FFFF;
        spin[p*SPIN_W +: SPIN_W] = SPIN_W'($urandom());
        stb[p] = ($urandom_range(0, 3) == 0);
      end
      sel_kp_n = NPORTS'($urandom());
      sel_js_n = NPORTS'($urandom());
      if ($urandom_range(0, 19) == 0) rotate = ~rotate;
      step_en();
      for (int p = 0; p < NPORTS; p++) begin
        checks++; if (ctrl_n[p*4 +: 4] !== m_ctrl[p]) begin errors++; $display("FAIL rnd_ctrl p%0d i%0d: got %b expected %b", p, i, ctrl_n[p*4 +: 4], m_ctrl[p]); end
        checks++; if (fire_n[p] !== m_fire[p]) begin errors++; $display("FAIL rnd_fire p%0d i%0d: got %b expected %b", p, i, fire_n[p], m_fire[p]); end
        checks++; if ({spa[p], spb[p]} !== exp_ab(p)) begin errors++; $display("FAIL rnd_spin p%0d i%0d: got %b expected %b", p, i, {spa[p], spb[p]}, exp_ab(p)); end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    sel_js_n = 2'b00;
    joy[3:0] = 4'b1010; joy[35:32] = 4'b0101; joy[4] = 1'b1;
    step_en();
    checks++; if (ctrl_n !== {m_ctrl[1], m_ctrl[0]}) begin errors++; $display("FAIL pre_reset_ctrl: got %b expected %b", ctrl_n, {m_ctrl[1], m_ctrl[0]}); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ctrl_n !== 8'hFF) begin errors++; $display("FAIL async_reset_ctrl: got %b expected %b", ctrl_n, 8'hFF); end
    checks++; if (fire_n !== 2'b11) begin errors++; $display("FAIL async_reset_fire: got %b expected %b", fire_n, 2'b11); end
    checks++; if ({spa, spb} !== 4'b1111) begin errors++; $display("FAIL async_reset_spin: got %b expected %b", {spa, spb}, 4'b1111); end
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    step_en();
    checks++; if (ctrl_n !== {m_ctrl[1], m_ctrl[0]}) begin errors++; $display("FAIL post_reset_ctrl: got %b expected %b", ctrl_n, {m_ctrl[1], m_ctrl[0]}); end
  endtask

  initial begin
    clear_inputs();
    clk_en = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_keypad();
    test_combined();
    test_rotate();
    test_spinner();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
